rmt_ingress_filter: RTL and testbench

Ingress classifier directly upstream of `rmt_wrapper`'s slave AXI-Stream port. It inspects the first beat of every packet. Qualifying VLAN/IPv4/UDP data and configuration packets are forwarded to the RMT pipeline, with one tuser bit marking configuration packets. Malformed, non-UDP and disallowed configuration packets are silently dropped. Per-class packet counters are exported for status registers.

---
 rtl/rmt_filter_pkg.sv | 40 ++++
 rtl/axis_skid_reg.sv | 63 ++++++
 rtl/rmt_ingress_filter.sv | 162 ++++++++++++++++
 tb/tb_rmt_ingress_filter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_filter_pkg.sv
// Header offsets, class/state encodings and the classification rule shared by
// the ingress filter and its bench.
package rmt_filter_pkg;

  localparam int          ETYPE_OFF     = 12;
  localparam logic [15:0] VLAN_ETYPE    = 16'h8100;
  localparam int          IP_ETYPE_OFF  = 16;
  localparam logic [15:0] IPV4_ETYPE    = 16'h0800;
  localparam int          IHL_OFF       = 18;
  localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
  localparam int          PROTO_OFF     = 27;
  localparam logic [7:0]  UDP_PROTO     = 8'h11;
  localparam int          UDP_DPORT_OFF = 40;
  localparam int          MIN_HDR_BYTES = 42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } filt_state_t;

  typedef enum logic [1:0] {
    CLS_DATA = 2'd0,
    CLS_CFG  = 2'd1,
    CLS_DROP = 2'd2
  } pkt_class_t;

  // Configuration packets are only a legal class while the host allows them.
  function automatic pkt_class_t classify(input logic well_formed,
                                          input logic cfg_port,
                                          input logic cfg_en);
    pkt_class_t cls;
    if (!well_formed)   cls = CLS_DROP;
    else if (!cfg_port) cls = CLS_DATA;
    else if (cfg_en)    cls = CLS_CFG;
    else                cls = CLS_DROP;
    return cls;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream output register: a main output slot plus one skid slot,
// so the upstream ready can be a flop while sustaining one beat per cycle.
module axis_skid_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int BEAT_W = DATA_WIDTH + DATA_WIDTH/8 + USER_WIDTH + 1;

  logic [BEAT_W-1:0] s_beat;
  logic [BEAT_W-1:0] m_beat_reg;
  logic [BEAT_W-1:0] skid_beat_reg;
  logic              m_valid_reg;
  logic              skid_valid_reg;
  logic              s_fire;

  assign s_beat  = {s_tdata, s_tkeep, s_tuser, s_tlast};
  assign s_ready = ~skid_valid_reg;
  assign s_fire  = s_valid & s_ready;

  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = m_beat_reg;
  assign m_valid = m_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_beat_reg     <= '0;
      skid_beat_reg  <= '0;
      m_valid_reg    <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!m_valid_reg || m_ready) begin
      // Output slot frees this cycle; the skid entry is older than any new beat.
      if (skid_valid_reg) begin
        m_beat_reg     <= skid_beat_reg;
        m_valid_reg    <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (s_fire) begin
        m_beat_reg  <= s_beat;
        m_valid_reg <= 1'b1;
      end else begin
        m_valid_reg <= 1'b0;
      end
    end else if (s_fire) begin
      skid_beat_reg  <= s_beat;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/rmt_ingress_filter.sv
// Classifies each packet on its first beat and forwards data/config packets to
// the RMT pipeline, tagging config packets in tuser; everything else is dropped.
module rmt_ingress_filter
  import rmt_filter_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CFG_UDP_DPORT        = 16'hF1F2,
  parameter int          CFG_TUSER_BIT        = 32,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              cfg_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

  filt_state_t state_reg, state_next;
  logic        cfg_pkt_reg, cfg_pkt_next;

  logic [15:0] etype;
  logic [15:0] ip_etype;
  logic [7:0]  ver_ihl;
  logic [7:0]  proto;
  logic [15:0] dport;
  logic        well_formed;
  logic        cfg_port;
  pkt_class_t  beat0_class;
  logic [2:0]  cls_hit;

  logic                            skid_ready;
  logic                            in_ready;
  logic                            in_fire;
  logic                            beat0_fire;
  logic                            fwd_valid;
  logic                            fwd_cfg;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] fwd_tuser;

  assign etype    = {s_axis_tdata[8*ETYPE_OFF +: 8], s_axis_tdata[8*(ETYPE_OFF+1) +: 8]};
  assign ip_etype = {s_axis_tdata[8*IP_ETYPE_OFF +: 8], s_axis_tdata[8*(IP_ETYPE_OFF+1) +: 8]};
  assign ver_ihl  = s_axis_tdata[8*IHL_OFF +: 8];
  assign proto    = s_axis_tdata[8*PROTO_OFF +: 8];
  assign dport    = {s_axis_tdata[8*UDP_DPORT_OFF +: 8], s_axis_tdata[8*(UDP_DPORT_OFF+1) +: 8]};

  assign well_formed = (etype == VLAN_ETYPE) && (ip_etype == IPV4_ETYPE) &&
                       (ver_ihl == IPV4_VER_IHL) && (proto == UDP_PROTO) &&
                       (&s_axis_tkeep[MIN_HDR_BYTES-1:0]);
  assign cfg_port    = (dport == CFG_UDP_DPORT);
  assign beat0_class = classify(well_formed, cfg_port, cfg_en);
  assign cls_hit     = {beat0_class == CLS_DROP, beat0_class == CLS_CFG, beat0_class == CLS_DATA};

  // DROP discards at line rate; IDLE still waits for the skid so the next
  // packet's first beat cannot be lost behind a full output stage.
  always_comb begin
    in_ready = skid_ready;
    if (rst)                    in_ready = 1'b0;
    else if (state_reg == DROP) in_ready = 1'b1;
  end

  assign s_axis_tready = in_ready;
  assign in_fire       = s_axis_tvalid & in_ready;
  assign beat0_fire    = in_fire && (state_reg == IDLE);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_cfg   = cfg_pkt_reg;
    case (state_reg)
      IDLE: begin
        fwd_valid = in_fire && (beat0_class != CLS_DROP);
        fwd_cfg   = (beat0_class == CLS_CFG);
      end
      PASS:    fwd_valid = in_fire;
      default: fwd_valid = 1'b0;
    endcase
  end

  always_comb begin
    fwd_tuser                = s_axis_tuser;
    fwd_tuser[CFG_TUSER_BIT] = fwd_cfg;
  end

  always_comb begin
    state_next   = state_reg;
    cfg_pkt_next = cfg_pkt_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          cfg_pkt_next = (beat0_class == CLS_CFG);
          if (!s_axis_tlast) state_next = (beat0_class == CLS_DROP) ? DROP : PASS;
        end
      end
      PASS, DROP: begin
        if (in_fire && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cfg_pkt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_pkt_reg <= cfg_pkt_next;
    end
  end

  // Counter index follows pkt_class_t: 0 data, 1 config, 2 drop.
  logic [CNT_WIDTH-1:0] cnt_out [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst)                             cnt_reg <= '0;
        else if (beat0_fire && cls_hit[gi])  cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
      assign cnt_out[gi] = cnt_reg;
    end
  endgenerate

  assign data_pkt_cnt = cnt_out[0];
  assign cfg_pkt_cnt  = cnt_out[1];
  assign drop_pkt_cnt = cnt_out[2];

  axis_skid_reg #(
    .DATA_WIDTH (C_S_AXIS_DATA_WIDTH),
    .USER_WIDTH (C_S_AXIS_TUSER_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_tdata (s_axis_tdata),
    .s_tkeep (s_axis_tkeep),
    .s_tuser (fwd_tuser),
    .s_tlast (s_axis_tlast),
    .s_valid (fwd_valid),
    .s_ready (skid_ready),
    .m_tdata (m_axis_tdata),
    .m_tkeep (m_axis_tkeep),
    .m_tuser (m_axis_tuser),
    .m_tlast (m_axis_tlast),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_rmt_ingress_filter.sv
// Directed bench for rmt_ingress_filter: classification, tuser tagging,
// counters, skid back-pressure and mid-packet reset.
module tb_rmt_ingress_filter;
  import rmt_filter_pkg::*;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 128;
  localparam int CW = 32;

  localparam logic [KW-1:0] KEEP_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [KW-1:0] KEEP_TAIL = 64'h0000_0000_000F_FFFF;
  localparam logic [KW-1:0] KEEP_SHORT = 64'h0000_0000_0000_FFFF;
  // Input tuser values and their expected forms after bit 32 is forced.
  localparam logic [UW-1:0] U_CFG_IN  = 128'h1111_2222_3333_4444_5555_6666_0000_0000;
  localparam logic [UW-1:0] U_CFG_EXP = 128'h1111_2222_3333_4444_5555_6667_0000_0000;
  localparam logic [UW-1:0] U_DAT_IN  = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_0001_0000_0000;
  localparam logic [UW-1:0] U_DAT_EXP = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [CW-1:0] data_cnt;
  logic [CW-1:0] cfg_cnt;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  rmt_ingress_filter dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_en        (cfg_en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .data_pkt_cnt  (data_cnt),
    .cfg_pkt_cnt   (cfg_cnt),
    .drop_pkt_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  toggle_en = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_hdr(input logic [11:0] vid, input logic [15:0] et12,
                                             input logic [7:0] proto, input logic [15:0] dport,
                                             input logic [7:0] tag);
    logic [DW-1:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = tag ^ 8'(i);
    d[8*12 +: 8] = et12[15:8];
    d[8*13 +: 8] = et12[7:0];
    d[8*14 +: 8] = {4'h0, vid[11:8]};
    d[8*15 +: 8] = vid[7:0];
    d[8*16 +: 8] = 8'h08;
    d[8*17 +: 8] = 8'h00;
    d[8*18 +: 8] = 8'h45;
    d[8*27 +: 8] = proto;
    d[8*40 +: 8] = dport[15:8];
    d[8*41 +: 8] = dport[7:0];
    return d;
  endfunction

  function automatic logic [DW-1:0] payload(input logic [7:0] pkt, input logic [7:0] beat);
    return {16{pkt, 8'hC3, beat, 8'h5A}};
  endfunction

  // Present one beat and hold it until accepted; waited = cycles spent.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input logic l, output int waited);
    logic acc;
    s_tdata  = d;
    s_tkeep  = k;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    waited   = 0;
    acc      = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard on handshakes, stability during stalls.
  beat_t prev_out;
  logic  prev_stall = 1'b0;
  logic  prev_rst   = 1'b1;

  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {m_tdata, m_tkeep, m_tuser, m_tlast};
    if (prev_stall && !rst && !prev_rst)
      check_eq("stall_stable", (cur == prev_out) && m_tvalid, 1);
    if (m_tvalid && m_tready && !rst) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", m_tdata, e.data);
        check_eq("out_keep", m_tkeep, e.keep);
        check_eq("out_user", m_tuser, e.user);
        check_eq("out_last", m_tlast, e.last);
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_out   = cur;
    prev_rst   = rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] h;
    logic [DW-1:0] d;
    int            w;
    int            bad_valid;
    int            bad_ready;

    rst = 1'b1; cfg_en = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", s_tready, 0);
    check_eq("rst_m_valid", m_tvalid, 0);
    check_eq("rst_m_data", m_tdata, 0);
    check_eq("rst_m_user", m_tuser, 0);
    check_eq("rst_m_last", m_tlast, 0);
    check_eq("rst_cnts", {data_cnt, cfg_cnt, drop_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Config packet forwarded with bit 32 set, one-cycle latency.
    h = make_hdr(12'd15, 16'h8100, 8'h11, 16'hF1F2, 8'h10);
    exp_q.push_back({h, KEEP_ALL, U_CFG_EXP, 1'b0});
    exp_q.push_back({payload(8'h01, 8'h01), KEEP_TAIL, U_CFG_EXP, 1'b1});
    send_beat(h, KEEP_ALL, U_CFG_IN, 1'b0, w);
    check_eq("lat_valid", m_tvalid, 1);
    check_eq("lat_data", m_tdata, h);
    send_beat(payload(8'h01, 8'h01), KEEP_TAIL, U_CFG_IN, 1'b1, w);
    s_tvalid = 1'b0;
    wait_drain();
    check_eq("cfg_cnt_1", cfg_cnt, 1);
    check_eq("data_cnt_0", data_cnt, 0);

    // Same packet with config disabled: dropped at line rate.
    cfg_en = 1'b0;
    send_beat(h, KEEP_ALL, U_CFG_IN, 1'b0, w);
    check_eq("drop_b0_wait", w, 1);
    send_beat(payload(8'h01, 8'h01), KEEP_TAIL, U_CFG_IN, 1'b1, w);
    check_eq("drop_b1_wait", w, 1);
    s_tvalid = 1'b0;
    cfg_en   = 1'b1;
    bad_valid = 0;
    bad_ready = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_tvalid) bad_valid++;
      if (!s_tready) bad_ready++;
    end
    check_eq("drop_no_valid", bad_valid, 0);
    check_eq("drop_ready_high", bad_ready, 0);
    check_eq("drop_cnt_1", drop_cnt, 1);
    check_eq("cfg_cnt_still_1", cfg_cnt, 1);
    @(posedge clk); #1;

    // Single-beat data packet: bit 32 cleared, FSM remains idle.
    h = make_hdr(12'd1, 16'h8100, 8'h11, 16'h10E1, 8'h30);
    exp_q.push_back({h, KEEP_ALL, U_DAT_EXP, 1'b1});
    send_beat(h, KEEP_ALL, U_DAT_IN, 1'b1, w);
    s_tvalid = 1'b0;
    check_eq("fsm_idle", dut.state_reg, IDLE);
    wait_drain();
    check_eq("data_cnt_1", data_cnt, 1);

    // Non-UDP, untagged ethertype, short keep: each a 2-beat dropped packet.
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       h = make_hdr(12'd5, 16'h8100, 8'h06, 16'h10E1, 8'h40);
        1:       h = make_hdr(12'd5, 16'h0800, 8'h11, 16'h10E1, 8'h41);
        default: h = make_hdr(12'd5, 16'h8100, 8'h11, 16'h10E1, 8'h42);
      endcase
      send_beat(h, (i == 2) ? KEEP_SHORT : KEEP_ALL, U_DAT_IN, 1'b0, w);
      send_beat(payload(8'h02, 8'(i)), KEEP_ALL, U_DAT_IN, 1'b1, w);
    end
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // One drop from the disabled config packet plus these three.
    check_eq("drop_cnt_4", drop_cnt, 4);
    check_eq("data_cnt_still_1", data_cnt, 1);

    // Five back-to-back 3-beat packets under toggling back-pressure.
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
      end
    join_none
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++) begin
        d = (b == 0) ? make_hdr(12'(100 + p), 16'h8100, 8'h11, 16'(16'h1000 + p), 8'(8'h50 + p))
                     : payload(8'(p), 8'(b));
        exp_q.push_back({d, KEEP_ALL, U_DAT_EXP, b == 2});
        send_beat(d, KEEP_ALL, U_DAT_IN, b == 2, w);
      end
    end
    s_tvalid = 1'b0;
    wait_drain();
    toggle_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b1;
    check_eq("data_cnt_6", data_cnt, 6);

    // Reset while the third beat of a packet is pending.
    m_tready = 1'b0;
    h = make_hdr(12'd7, 16'h8100, 8'h11, 16'h2000, 8'h70);
    send_beat(h, KEEP_ALL, U_DAT_IN, 1'b0, w);
    send_beat(payload(8'h09, 8'h01), KEEP_ALL, U_DAT_IN, 1'b0, w);
    check_eq("pre_rst_data_cnt", data_cnt, 7);
    s_tdata = payload(8'h09, 8'h02);
    s_tlast = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ready", s_tready, 0);
    @(posedge clk); #1;
    check_eq("rst_mid_valid", m_tvalid, 0);
    check_eq("rst_mid_cnts", {data_cnt, cfg_cnt, drop_cnt}, 0);
    rst      = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    h = make_hdr(12'd8, 16'h8100, 8'h11, 16'h3000, 8'h80);
    exp_q.push_back({h, KEEP_ALL, U_DAT_EXP, 1'b1});
    send_beat(h, KEEP_ALL, U_DAT_IN, 1'b1, w);
    s_tvalid = 1'b0;
    wait_drain();
    check_eq("post_rst_data_cnt", data_cnt, 1);
    check_eq("post_rst_drop_cnt", drop_cnt, 0);

    repeat (3) @(posedge clk);
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
